// File: rtl/huff_pkg.sv
// ---------------------------------------------------------------------------
// huff_pkg
// Shared definitions for the Huffman encode datapath.
//   HUFF_AW      default address width, matches the encoder table depth
//   MODE_SINGLE  run one pass from base to limit, then report done
//   MODE_WRAP    restart at base after every pass, report wrap
//   seq_state_e  sequencer state encoding (IDLE / RUN)
// ---------------------------------------------------------------------------
package huff_pkg;

   localparam int HUFF_AW = 8;

   localparam logic MODE_SINGLE = 1'b0;
   localparam logic MODE_WRAP   = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_e;

endpackage : huff_pkg

// File: rtl/addr_seq_gen.sv
// ---------------------------------------------------------------------------
// addr_seq_gen
// Strided address sequencer feeding the table-read and symbol-fetch stages.
// Walks base, base+stride, ... up to limit, either once or circularly, and
// presents each address over a valid/ready handshake.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               pulse, latches config and begins a run from IDLE
//   stop                aborts a run in progress
//   cfg_mode            0 = single pass, 1 = wrap continuously
//   cfg_base/limit      first address / highest allowed address
//   cfg_stride          increment per accepted beat (0 is treated as 1)
//   addr, addr_valid    address offered to the consumer
//   addr_ready          consumer accepts the address this cycle
//   addr_last           current address is the final one of its pass
//   wrap                one-cycle pulse when a wrap pass restarts at base
//   done                one-cycle pulse when a single pass completes
//   busy                sequencer is running
// ---------------------------------------------------------------------------
module addr_seq_gen
   import huff_pkg::*;
#(
   parameter int AW = HUFF_AW,
   parameter int SW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          cfg_mode,
   input  logic [AW-1:0] cfg_base,
   input  logic [AW-1:0] cfg_limit,
   input  logic [SW-1:0] cfg_stride,
   output logic [AW-1:0] addr,
   output logic          addr_valid,
   input  logic          addr_ready,
   output logic          addr_last,
   output logic          wrap,
   output logic          done,
   output logic          busy
);

   seq_state_e    state_q;
   logic [AW-1:0] addr_q;
   logic          valid_q;
   logic          wrap_q;
   logic          done_q;
   logic          mode_q;
   logic [AW-1:0] base_q;
   logic [AW-1:0] limit_q;
   logic [SW-1:0] stride_q;

   logic [AW:0]   nxt_d;
   logic          last_d;
   logic          fire_d;
   logic [SW-1:0] cfgStride_d;

   // The next address is formed one bit wider than the address so that a
   // step past the top of the address space shows up as a carry and is
   // treated as "beyond limit" rather than silently wrapping to a low value.
   // A zero stride would stall the sequence forever, so it is promoted to 1.
   always_comb begin
      nxt_d       = {1'b0, addr_q} + (AW+1)'(stride_q);
      last_d      = (state_q == ST_RUN) && (nxt_d > {1'b0, limit_q});
      fire_d      = valid_q && addr_ready;
      cfgStride_d = (cfg_stride == '0) ? SW'(1) : cfg_stride;
   end

   // Single FSM that owns the address register and all status outputs.
   // Config is captured only when a run begins, so the upstream block may
   // change cfg_* freely while a run is in flight. Stop takes priority over
   // the end-of-pass handling: a beat accepted in the stop cycle is still
   // consumed downstream, but neither done nor wrap is reported. The address
   // is left untouched on stop and on single-pass completion so the consumer
   // can still see where the run ended.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         valid_q  <= 1'b0;
         wrap_q   <= 1'b0;
         done_q   <= 1'b0;
         mode_q   <= MODE_SINGLE;
         base_q   <= '0;
         limit_q  <= '0;
         stride_q <= '0;
      end else begin
         wrap_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q  <= ST_RUN;
                  addr_q   <= cfg_base;
                  valid_q  <= 1'b1;
                  mode_q   <= cfg_mode;
                  base_q   <= cfg_base;
                  limit_q  <= cfg_limit;
                  stride_q <= cfgStride_d;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
               end else if (fire_d) begin
                  if (!last_d) begin
                     addr_q <= nxt_d[AW-1:0];
                  end else if (mode_q == MODE_WRAP) begin
                     addr_q <= base_q;
                     wrap_q <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Outputs come straight from registers, except addr_last which must
   // follow the current address combinationally.
   always_comb begin
      addr       = addr_q;
      addr_valid = valid_q;
      addr_last  = last_d;
      wrap       = wrap_q;
      done       = done_q;
      busy       = (state_q == ST_RUN);
   end

endmodule : addr_seq_gen

// File: tb/tb_addr_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_addr_seq_gen
// Self-checking bench for addr_seq_gen. A reference model describes each pass
// as a precomputed list of addresses and simply steps an index through it.
// ---------------------------------------------------------------------------
module tb_addr_seq_gen;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       cfg_mode;
   logic [7:0] cfg_base;
   logic [7:0] cfg_limit;
   logic [3:0] cfg_stride;
   logic [7:0] addr;
   logic       addr_valid;
   logic       addr_ready;
   logic       addr_last;
   logic       wrap;
   logic       done;
   logic       busy;

   int checkCount = 0;
   int failCount  = 0;

   int mPass[$];
   int mIdx;
   bit mRun;
   bit mMode;
   int mAddr;
   bit mAddrKnown;
   bit mDone;
   bit mWrap;

   bit captureEn;
   int firedAddrs[$];

   addr_seq_gen #(.AW(8), .SW(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .cfg_mode   (cfg_mode),
      .cfg_base   (cfg_base),
      .cfg_limit  (cfg_limit),
      .cfg_stride (cfg_stride),
      .addr       (addr),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .addr_last  (addr_last),
      .wrap       (wrap),
      .done       (done),
      .busy       (busy)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // A pass is every address base, base+s, ... that does not exceed limit;
   // the base itself is always emitted even when limit is below it.
   task automatic buildPass(input int base, input int limit, input int stride);
      int s;
      int a;
      s = (stride == 0) ? 1 : stride;
      a = base;
      mPass.delete();
      do begin
         mPass.push_back(a);
         a += s;
      end while (a <= limit);
   endtask

   // One clock cycle: compare the DUT against the model at the falling edge,
   // drive the new inputs, advance the model, then let the rising edge happen.
   task automatic applyStimulus(input bit iStart, input bit iStop, input bit iReady,
                                input bit iRst, input bit iMode, input int iBase,
                                input int iLimit, input int iStride);
      bit isLast;
      @(negedge clk);
      checkOutput("addr_valid", addr_valid, mRun);
      checkOutput("busy", busy, mRun);
      checkOutput("done", done, mDone);
      checkOutput("wrap", wrap, mWrap);
      checkOutput("addr_last", addr_last, mRun && (mIdx == mPass.size() - 1));
      if (mRun)
         checkOutput("addr_run", addr, mPass[mIdx]);
      else if (mAddrKnown)
         checkOutput("addr_idle", addr, mAddr);

      start      = iStart;
      stop       = iStop;
      addr_ready = iReady;
      rst        = iRst;
      cfg_mode   = iMode;
      cfg_base   = 8'(iBase);
      cfg_limit  = 8'(iLimit);
      cfg_stride = 4'(iStride);

      if (captureEn && mRun && iReady && !iRst)
         firedAddrs.push_back(int'(addr));

      if (iRst) begin
         mRun       = 1'b0;
         mAddr      = 0;
         mAddrKnown = 1'b1;
         mDone      = 1'b0;
         mWrap      = 1'b0;
      end else begin
         mDone = 1'b0;
         mWrap = 1'b0;
         if (!mRun) begin
            if (iStart) begin
               buildPass(iBase, iLimit, iStride);
               mRun  = 1'b1;
               mIdx  = 0;
               mMode = iMode;
            end
         end else begin
            isLast = (mIdx == mPass.size() - 1);
            if (iStop) begin
               mRun       = 1'b0;
               mAddrKnown = 1'b0;
            end else if (iReady) begin
               if (!isLast) begin
                  mIdx++;
               end else if (mMode) begin
                  mIdx  = 0;
                  mWrap = 1'b1;
               end else begin
                  mAddr      = mPass[mIdx];
                  mAddrKnown = 1'b1;
                  mRun       = 1'b0;
                  mDone      = 1'b1;
               end
            end
         end
      end
      @(posedge clk);
   endtask

   task automatic idleCycles(input int n, input bit ready);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 1'b0, ready, 1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic checkFired(input string tag, input int expList[$]);
      checkOutput({tag, "_count"}, firedAddrs.size(), expList.size());
      for (int i = 0; i < expList.size() && i < firedAddrs.size(); i++)
         checkOutput(tag, firedAddrs[i], expList[i]);
      firedAddrs.delete();
   endtask

   // Directed scenarios first, then a long randomized soak.
   initial begin
      int expList[$];
      int b;
      int l;
      rst        = 1'b1;
      start      = 1'b0;
      stop       = 1'b0;
      cfg_mode   = 1'b0;
      cfg_base   = '0;
      cfg_limit  = '0;
      cfg_stride = '0;
      addr_ready = 1'b0;
      captureEn  = 1'b0;
      mRun       = 1'b0;
      mIdx       = 0;
      mMode      = 1'b0;
      mAddr      = 0;
      mAddrKnown = 1'b1;
      mDone      = 1'b0;
      mWrap      = 1'b0;
      repeat (2) @(posedge clk);

      $display("[TB] reset then idle");
      idleCycles(10, 1'b0);

      $display("[TB] single pass 4..10 stride 2");
      captureEn = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4, 10, 2);
      idleCycles(7, 1'b1);
      expList = '{4, 6, 8, 10};
      checkFired("single_pass", expList);

      $display("[TB] wrap 0..3 with backpressure");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 1);
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b0, 1'b0, i[0], 1'b0, 1'b0, 0, 0, 0);
      expList = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
      checkFired("wrap_seq", expList);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      idleCycles(2, 1'b0);

      $display("[TB] top of address space 250..255 stride 3");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 250, 255, 3);
      idleCycles(5, 1'b1);
      expList = '{250, 253};
      checkFired("top_range", expList);

      $display("[TB] stride 0 acts as 1");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5, 8, 0);
      idleCycles(6, 1'b1);
      expList = '{5, 6, 7, 8};
      checkFired("stride0", expList);

      $display("[TB] limit below base");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9, 3, 2);
      idleCycles(3, 1'b1);
      expList = '{9};
      checkFired("limit_lt_base", expList);
      captureEn = 1'b0;

      $display("[TB] stop on third beat");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 20, 1);
      idleCycles(2, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
      idleCycles(3, 1'b1);

      $display("[TB] reset mid-run");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10, 40, 3);
      idleCycles(3, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
      idleCycles(3, 1'b1);

      $display("[TB] start during run, start with stop in idle");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20, 30, 5);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 100, 200, 1);
      idleCycles(4, 1'b1);

      $display("[TB] full address range");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 255, 1);
      idleCycles(260, 1'b1);

      $display("[TB] random soak");
      for (int i = 0; i < 3000; i++) begin
         b = $urandom_range(0, 255);
         l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                         : b + $urandom_range(0, 30);
         if (l > 255) l = 255;
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                       $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0,
                       1'($urandom_range(0, 1)), b, l, $urandom_range(0, 15));
      end
      idleCycles(2, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule : tb_addr_seq_gen
